// File: rtl/div_iter_pkg.sv
// rtl/div_iter_pkg.sv - shared constants for the iterative divider
// Purpose: default operand width, FSM state codes and handshake level names.
// Ports: none (package).
package div_iter_pkg;

    localparam int DIV_WD = 32;

    localparam logic [1:0] DIV_FREE    = 2'b00;
    localparam logic [1:0] DIV_BYZERO  = 2'b01;
    localparam logic [1:0] DIV_ON      = 2'b10;
    localparam logic [1:0] DIV_END     = 2'b11;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_iter_if.sv
// rtl/div_iter_if.sv - EX <-> divider handshake bundle
// Purpose: groups the divide request, operands and result/ready signals.
// Ports (signals): signed_div_i, opdata1_i, opdata2_i, start_i, annul_i driven by EX
//   (master); result_o {remainder, quotient} and ready_o driven by the divider (slave).
interface div_iter_if
    import div_iter_pkg::*;
#(
    parameter int WD = DIV_WD
);
    logic            signed_div_i;
    logic [WD-1:0]   opdata1_i;
    logic [WD-1:0]   opdata2_i;
    logic            start_i;
    logic            annul_i;
    logic [2*WD-1:0] result_o;
    logic            ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_iter.sv
// rtl/div_iter.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
// Purpose: WD-step restoring division on operand magnitudes plus a final sign fix.
// Ports: clk, rst (async, active-high); bus (div_iter_if.slave) carrying
//   signed_div_i, opdata1_i, opdata2_i, start_i, annul_i in and
//   result_o = {remainder, quotient}, ready_o out (both registered).
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WD = DIV_WD
) (
    input  logic        clk,
    input  logic        rst,
    div_iter_if.slave   bus
);

    localparam int              CW       = $clog2(WD + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WD);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    // The remainder is always below the divisor, so its extra (WD+1th) bit is
    // only ever non-zero in the shifted/trial path and is not stored.
    logic [WD-1:0] rem;
    logic [WD-1:0] quo;
    logic [WD-1:0] divisor;
    logic          neg_quo;
    logic          neg_rem;

    logic [WD:0]   rem_sh;
    logic [WD:0]   trial;
    logic [WD-1:0] abs_op1;
    logic [WD-1:0] abs_op2;
    logic [WD-1:0] quo_fix;
    logic [WD-1:0] rem_fix;

    always_comb begin
        rem_sh  = {rem, quo[WD-1]};
        trial   = rem_sh - {1'b0, divisor};
        // Negating 0x80..0 yields 0x80..0, which is the correct unsigned magnitude.
        abs_op1 = (bus.signed_div_i && bus.opdata1_i[WD-1]) ? -bus.opdata1_i : bus.opdata1_i;
        abs_op2 = (bus.signed_div_i && bus.opdata2_i[WD-1]) ? -bus.opdata2_i : bus.opdata2_i;
        quo_fix = neg_quo ? -quo : quo;
        rem_fix = neg_rem ? -rem : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= DIV_FREE;
            cnt          <= '0;
            rem          <= '0;
            quo          <= '0;
            divisor      <= '0;
            neg_quo      <= 1'b0;
            neg_rem      <= 1'b0;
            bus.ready_o  <= DIV_RESULT_NOT_READY;
            bus.result_o <= '0;
        end else begin
            case (state)
                DIV_FREE: begin
                    bus.ready_o  <= DIV_RESULT_NOT_READY;
                    bus.result_o <= '0;
                    if (bus.start_i == DIV_START && !bus.annul_i) begin
                        state   <= (bus.opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                        quo     <= abs_op1;
                        divisor <= abs_op2;
                        rem     <= '0;
                        cnt     <= '0;
                        neg_quo <= bus.signed_div_i & (bus.opdata1_i[WD-1] ^ bus.opdata2_i[WD-1]);
                        neg_rem <= bus.signed_div_i & bus.opdata1_i[WD-1];
                    end
                end
                DIV_BYZERO: begin
                    // Result is defined as zero; ready rises on the following
                    // cycle from DIV_END while EX still holds start.
                    state        <= bus.annul_i ? DIV_FREE : DIV_END;
                    bus.ready_o  <= DIV_RESULT_NOT_READY;
                    bus.result_o <= '0;
                end
                DIV_ON: begin
                    if (bus.annul_i) begin
                        state        <= DIV_FREE;
                        bus.ready_o  <= DIV_RESULT_NOT_READY;
                        bus.result_o <= '0;
                    end else if (cnt != CNT_LAST) begin
                        rem <= trial[WD] ? rem_sh[WD-1:0] : trial[WD-1:0];
                        quo <= {quo[WD-2:0], ~trial[WD]};
                        cnt <= cnt + CW'(1);
                    end else begin
                        state        <= DIV_END;
                        cnt          <= '0;
                        bus.ready_o  <= DIV_RESULT_READY;
                        bus.result_o <= {rem_fix, quo_fix};
                    end
                end
                default: begin
                    if (bus.annul_i || bus.start_i == DIV_STOP) begin
                        state        <= DIV_FREE;
                        bus.ready_o  <= DIV_RESULT_NOT_READY;
                        bus.result_o <= '0;
                    end else begin
                        bus.ready_o  <= DIV_RESULT_READY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - self-checking bench for div_iter
module tb_div_iter;

    localparam int WD = 32;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    logic [63:0] exp_result;

    div_iter_if #(.WD(WD)) bus();

    div_iter #(.WD(WD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(bit sg, logic [31:0] a, logic [31:0] b);
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
        end
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Whenever the divider is not reporting ready its result must read zero;
    // when it is, the result must match the model for the current request.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ready_o) chk("cmp_result_ready", bus.result_o, exp_result);
            else             chk("cmp_result_idle", bus.result_o, 64'd0);
        end
    end

    task automatic start_op(bit sg, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        bus.signed_div_i = sg;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        exp_result       = model(sg, a, b);
    endtask

    task automatic wait_ready(output int k, output bit seen);
        seen = 1'b0;
        k    = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~bus.signed_div_i;
            end
            if (bus.ready_o) begin
                seen = 1'b1;
                k    = i;
                break;
            end
        end
    endtask

    task automatic watch_no_ready(string name, int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) seen = 1'b1;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    task automatic do_div(bit sg, logic [31:0] a, logic [31:0] b);
        int k;
        bit seen;
        start_op(sg, a, b);
        wait_ready(k, seen);
        bus.start_i = 1'b0;
        chk("latency", 64'(k), (b == 32'd0) ? 64'd2 : 64'(WD + 1));
        chk("result", bus.result_o, model(sg, a, b));
        @(posedge clk);
        #1;
        chk("ready_pulse", 64'(bus.ready_o), 64'd0);
    endtask

    initial begin
        int k;
        bit seen;
        n_assert         = 0;
        n_fail           = 0;
        exp_result       = 64'd0;
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;

        @(posedge clk);
        #1;
        chk("reset_ready", 64'(bus.ready_o), 64'd0);
        chk("reset_result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        chk("model_divu_100_7", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        chk("model_div_m7_2", model(1'b1, 32'hFFFFFFF9, 32'd2), {32'hFFFFFFFF, 32'hFFFFFFFD});
        chk("model_div_7_m2", model(1'b1, 32'd7, 32'hFFFFFFFE), {32'h1, 32'hFFFFFFFD});
        chk("model_div_min_m1", model(1'b1, 32'h80000000, 32'hFFFFFFFF), {32'h0, 32'h80000000});

        do_div(1'b0, 32'd100, 32'd7);
        chk("lit_divu_100_7", bus.result_o, 64'd0);
        do_div(1'b1, 32'hFFFFFFF9, 32'd2);
        do_div(1'b1, 32'd7, 32'hFFFFFFFE);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
        do_div(1'b0, 32'hFFFFFFFF, 32'd1);
        do_div(1'b0, 32'h80000000, 32'hFFFFFFFF);
        do_div(1'b0, 32'd5, 32'd0);
        do_div(1'b1, 32'hFFFFFFFB, 32'd0);
        do_div(1'b1, 32'h80000000, 32'h80000000);
        do_div(1'b0, 32'd3, 32'd10);

        // Annul mid-divide: no result may ever appear.
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        watch_no_ready("annul_on_no_ready", 40);
        do_div(1'b0, 32'd9, 32'd3);

        // Annul wins over start in IDLE.
        @(negedge clk);
        bus.opdata1_i = 32'd50;
        bus.opdata2_i = 32'd5;
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        watch_no_ready("annul_beats_start", 40);

        // Held start keeps END; annul then clears it.
        start_op(1'b0, 32'd77, 32'd7);
        wait_ready(k, seen);
        chk("end_first_ready", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        chk("end_hold_ready", 64'(bus.ready_o), 64'd1);
        chk("end_hold_result", bus.result_o, {32'd0, 32'd11});
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        chk("annul_end_ready", 64'(bus.ready_o), 64'd0);
        chk("annul_end_result", bus.result_o, 64'd0);

        // Back-to-back with one start-low cycle in between.
        do_div(1'b1, 32'hFFFFFF9C, 32'd7);
        do_div(1'b0, 32'd1000, 32'd33);

        // Asynchronous reset mid-divide.
        start_op(1'b1, 32'hFFFFFC18, 32'd7);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_on_ready", 64'(bus.ready_o), 64'd0);
        chk("rst_on_result", bus.result_o, 64'd0);
        @(negedge clk);
        rst         = 1'b0;
        bus.start_i = 1'b0;
        watch_no_ready("rst_on_no_ready", 40);

        // Asynchronous reset while a result is presented.
        start_op(1'b0, 32'd200, 32'd9);
        wait_ready(k, seen);
        chk("rst_end_seen", 64'(seen), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_end_ready", 64'(bus.ready_o), 64'd0);
        chk("rst_end_result", bus.result_o, 64'd0);
        @(negedge clk);
        rst         = 1'b0;
        bus.start_i = 1'b0;

        do_div(1'b0, 32'd12345, 32'h77);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
